daq_cmd_sequencer: RTL and testbench

//  Parametrised fast-command sequencer for the DAQ. Decodes the opcode on cmd_code,

---
 rtl/daq_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_daq_cmd_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/daq_cmd_sequencer.sv
// Fast-command sequencer: decodes DAQ opcodes into channel enables and a time-reset
// pulse, and logs every accepted command into a FIFO read and acknowledged by the HPS.
module daq_cmd_sequencer #(
    parameter int unsigned N_CHAN     = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RST_PULSE  = 4
) (
    input  logic                          clk_50,
    input  logic                          rst,
    input  logic [3:0]                    cmd_code,
    input  logic [N_CHAN-1:0]             cmd_chan_mask,
    input  logic                          h2f_ack_cmd,
    output logic                          enable_acq,
    output logic [N_CHAN-1:0]             chan_en,
    output logic                          rst_time,
    output logic                          f2h_notify_cmd,
    output logic [3:0]                    cmd_code_mem,
    output logic [$clog2(FIFO_DEPTH):0]   cmd_fifo_level,
    output logic                          cmd_overflow
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(RST_PULSE + 1);

    localparam logic [3:0] OP_RESET_DIF  = 4'h0;
    localparam logic [3:0] OP_RESET_BCID = 4'h1;
    localparam logic [3:0] OP_START      = 4'h2;
    localparam logic [3:0] OP_RAMFULL    = 4'h3;
    localparam logic [3:0] OP_STOP       = 4'h5;
    localparam logic [3:0] OP_IDLE       = 4'hE;

    typedef enum logic [1:0] {
        S_RESETTING = 2'd0,
        S_STOPPED   = 2'd1,
        S_RUNNING   = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_CHAN-1:0]  chan_en_q;
    logic               enable_acq_q;
    logic               rst_time_q;

    logic [3:0]         cmd_prev_q;
    logic               ack_prev_q;
    logic [3:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [3:0]         head_q, head_d;
    logic               notify_q;
    logic               overflow_q;

    logic               cmd_event;
    logic               is_reset_cmd;
    logic               pop_ok;
    logic               push_ok;
    logic               drop;
    logic               fifo_full;

    // Event detection and log FIFO next-state
    always_comb begin
        cmd_event    = (cmd_code != cmd_prev_q) && (cmd_code != OP_IDLE);
        is_reset_cmd = cmd_event && ((cmd_code == OP_RESET_DIF) || (cmd_code == OP_RESET_BCID));
        fifo_full    = (level_q == LVL_W'(FIFO_DEPTH));
        pop_ok       = h2f_ack_cmd && !ack_prev_q && (level_q != '0);
        push_ok      = cmd_event && (!fifo_full || pop_ok);
        drop         = cmd_event && fifo_full && !pop_ok;
        wr_ptr_d     = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d      = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
        end
        // The new head may be the entry being written this cycle
        if (level_d == '0) begin
            head_d = OP_IDLE;
        end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_d = cmd_code;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control FSM with registered enables and time-reset pulse
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q      <= S_RESETTING;
            cnt_q        <= CNT_W'(RST_PULSE - 1);
            rst_time_q   <= 1'b1;
            chan_en_q    <= '0;
            enable_acq_q <= 1'b0;
        end else if (is_reset_cmd) begin
            state_q      <= S_RESETTING;
            cnt_q        <= CNT_W'(RST_PULSE - 1);
            rst_time_q   <= 1'b1;
            chan_en_q    <= '0;
            enable_acq_q <= 1'b0;
        end else begin
            case (state_q)
                S_RESETTING: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_STOPPED;
                        rst_time_q <= 1'b0;
                    end else begin
                        cnt_q      <= cnt_q - 1'b1;
                        rst_time_q <= 1'b1;
                    end
                end
                S_STOPPED: begin
                    if (cmd_event && (cmd_code == OP_START) && (cmd_chan_mask != '0)) begin
                        state_q      <= S_RUNNING;
                        chan_en_q    <= cmd_chan_mask;
                        enable_acq_q <= 1'b1;
                    end
                end
                S_RUNNING: begin
                    if (cmd_event && ((cmd_code == OP_STOP) || (cmd_code == OP_RAMFULL))) begin
                        state_q      <= S_STOPPED;
                        chan_en_q    <= '0;
                        enable_acq_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_RESETTING;
                    cnt_q        <= CNT_W'(RST_PULSE - 1);
                    rst_time_q   <= 1'b1;
                    chan_en_q    <= '0;
                    enable_acq_q <= 1'b0;
                end
            endcase
        end
    end

    // Log FIFO control and edge-detect history
    always_ff @(posedge clk_50) begin
        if (rst) begin
            cmd_prev_q <= OP_IDLE;
            ack_prev_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_q     <= OP_IDLE;
            notify_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cmd_prev_q <= cmd_code;
            ack_prev_q <= h2f_ack_cmd;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            head_q     <= head_d;
            notify_q   <= (level_d != '0);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Log storage needs no reset: reads are gated by the level
    always_ff @(posedge clk_50) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= cmd_code;
        end
    end

    assign enable_acq     = enable_acq_q;
    assign chan_en        = chan_en_q;
    assign rst_time       = rst_time_q;
    assign f2h_notify_cmd = notify_q;
    assign cmd_code_mem   = head_q;
    assign cmd_fifo_level = level_q;
    assign cmd_overflow   = overflow_q;

endmodule

// File: tb/tb_daq_cmd_sequencer.sv
// Directed bench for daq_cmd_sequencer: vector table for the command/FSM flow plus
// hand-written sequences for mid-run reset, FIFO overflow, held ack and draining.
module tb_daq_cmd_sequencer;

    logic       clk_50 = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cmd_code = 4'hE;
    logic [3:0] cmd_chan_mask = 4'h0;
    logic       h2f_ack_cmd = 1'b0;
    logic       enable_acq;
    logic [3:0] chan_en;
    logic       rst_time;
    logic       f2h_notify_cmd;
    logic [3:0] cmd_code_mem;
    logic [3:0] cmd_fifo_level;
    logic       cmd_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    daq_cmd_sequencer #(.N_CHAN(4), .FIFO_DEPTH(8), .RST_PULSE(4)) dut (
        .clk_50        (clk_50),
        .rst           (rst),
        .cmd_code      (cmd_code),
        .cmd_chan_mask (cmd_chan_mask),
        .h2f_ack_cmd   (h2f_ack_cmd),
        .enable_acq    (enable_acq),
        .chan_en       (chan_en),
        .rst_time      (rst_time),
        .f2h_notify_cmd(f2h_notify_cmd),
        .cmd_code_mem  (cmd_code_mem),
        .cmd_fifo_level(cmd_fifo_level),
        .cmd_overflow  (cmd_overflow)
    );

    always #5 clk_50 = ~clk_50;

    typedef struct {
        logic       rst;
        logic [3:0] code;
        logic [3:0] mask;
        logic       ack;
        logic [3:0] e_chan;
        logic       e_en;
        logic       e_rt;
        logic [3:0] e_lvl;
        logic [3:0] e_mem;
        logic       e_ovf;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [3:0] c, input logic [3:0] m,
                                input logic a, input logic [3:0] ch, input logic en,
                                input logic rt, input logic [3:0] lv, input logic [3:0] me,
                                input logic ov);
        vec_t v;
        v.rst = r; v.code = c; v.mask = m; v.ack = a;
        v.e_chan = ch; v.e_en = en; v.e_rt = rt; v.e_lvl = lv; v.e_mem = me; v.e_ovf = ov;
        return v;
    endfunction

    task automatic step(input logic r, input logic [3:0] c, input logic [3:0] m, input logic a);
        rst = r; cmd_code = c; cmd_chan_mask = m; h2f_ack_cmd = a;
        @(posedge clk_50);
        #1;
    endtask

    task automatic check_all(input string name, input logic [3:0] ch, input logic en,
                             input logic rt, input logic [3:0] lv, input logic [3:0] me,
                             input logic ov);
        logic [15:0] act, exp;
        act = {chan_en, enable_acq, rst_time, f2h_notify_cmd, cmd_fifo_level, cmd_code_mem, cmd_overflow};
        exp = {ch, en, rt, (lv != 4'd0), lv, me, ov};
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got chan=%h en=%b rt=%b ntf=%b lvl=%0d mem=%h ovf=%b, want chan=%h en=%b rt=%b ntf=%b lvl=%0d mem=%h ovf=%b",
                     name, chan_en, enable_acq, rst_time, f2h_notify_cmd, cmd_fifo_level,
                     cmd_code_mem, cmd_overflow, ch, en, rt, (lv != 4'd0), lv, me, ov);
        end
    endtask

    initial begin
        logic [3:0] ovf_codes [9];
        logic [3:0] drain_codes [8];

        //                rst code mask ack  chan en rt lvl mem ovf
        vecs[0]  = mk(1'b1, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 4'hE, 1'b0);
        vecs[1]  = mk(1'b1, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 4'hE, 1'b0);
        vecs[2]  = mk(1'b1, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 4'hE, 1'b0);
        vecs[3]  = mk(1'b0, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 4'hE, 1'b0);
        vecs[4]  = mk(1'b0, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 4'hE, 1'b0);
        vecs[5]  = mk(1'b0, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 4'hE, 1'b0);
        vecs[6]  = mk(1'b0, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 4'hE, 1'b0);
        vecs[7]  = mk(1'b0, 4'h2, 4'h5, 1'b0, 4'h5, 1'b1, 1'b0, 4'd1, 4'h2, 1'b0);
        vecs[8]  = mk(1'b0, 4'h2, 4'h5, 1'b0, 4'h5, 1'b1, 1'b0, 4'd1, 4'h2, 1'b0);
        vecs[9]  = mk(1'b0, 4'h2, 4'hF, 1'b0, 4'h5, 1'b1, 1'b0, 4'd1, 4'h2, 1'b0);
        vecs[10] = mk(1'b0, 4'h2, 4'hF, 1'b0, 4'h5, 1'b1, 1'b0, 4'd1, 4'h2, 1'b0);
        vecs[11] = mk(1'b0, 4'h3, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'd2, 4'h2, 1'b0);
        vecs[12] = mk(1'b0, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'd3, 4'h2, 1'b0);
        vecs[13] = mk(1'b0, 4'h2, 4'h3, 1'b0, 4'h0, 1'b0, 1'b1, 4'd4, 4'h2, 1'b0);
        vecs[14] = mk(1'b0, 4'hE, 4'h3, 1'b0, 4'h0, 1'b0, 1'b1, 4'd4, 4'h2, 1'b0);
        vecs[15] = mk(1'b0, 4'hE, 4'h3, 1'b0, 4'h0, 1'b0, 1'b1, 4'd4, 4'h2, 1'b0);
        vecs[16] = mk(1'b0, 4'hE, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0, 4'd4, 4'h2, 1'b0);
        vecs[17] = mk(1'b0, 4'h2, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd5, 4'h2, 1'b0);
        vecs[18] = mk(1'b0, 4'h5, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd6, 4'h2, 1'b0);
        vecs[19] = mk(1'b0, 4'hE, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'd5, 4'h3, 1'b0);
        vecs[20] = mk(1'b0, 4'hE, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'd5, 4'h3, 1'b0);
        vecs[21] = mk(1'b0, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd5, 4'h3, 1'b0);
        vecs[22] = mk(1'b0, 4'h7, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'd5, 4'h1, 1'b0);
        vecs[23] = mk(1'b0, 4'h7, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd5, 4'h1, 1'b0);
        vecs[24] = mk(1'b0, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'd5, 4'h1, 1'b0);
        vecs[25] = mk(1'b0, 4'h2, 4'h6, 1'b0, 4'h6, 1'b1, 1'b0, 4'd6, 4'h1, 1'b0);
        vecs[26] = mk(1'b0, 4'h5, 4'h6, 1'b0, 4'h0, 1'b0, 1'b0, 4'd7, 4'h1, 1'b0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].code, vecs[i].mask, vecs[i].ack);
            check_all($sformatf("vec%0d", i), vecs[i].e_chan, vecs[i].e_en, vecs[i].e_rt,
                      vecs[i].e_lvl, vecs[i].e_mem, vecs[i].e_ovf);
        end

        // Reset while running aborts everything, then a fresh 4-cycle pulse
        step(1'b0, 4'h2, 4'hF, 1'b0);
        check_all("restart_run", 4'hF, 1'b1, 1'b0, 4'd8, 4'h1, 1'b0);
        step(1'b1, 4'hE, 4'h0, 1'b0);
        check_all("midrun_rst", 4'h0, 1'b0, 1'b1, 4'd0, 4'hE, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'hE, 4'h0, 1'b0);
            check_all($sformatf("post_rst_pulse%0d", i), 4'h0, 1'b0, (i < 3), 4'd0, 4'hE, 1'b0);
        end

        // Nine distinct events with no ack: eighth fills, ninth is dropped
        ovf_codes = '{4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF, 4'h6};
        for (int i = 0; i < 9; i++) begin
            step(1'b0, ovf_codes[i], 4'h0, 1'b0);
            check_all($sformatf("fill%0d", i), 4'h0, 1'b0, 1'b0,
                      (i < 8) ? 4'(i + 1) : 4'd8, 4'h7, (i == 8));
        end

        // Push and pop together while full keep the level; held ack pops only once
        step(1'b0, 4'h4, 4'h0, 1'b1);
        check_all("full_push_pop", 4'h0, 1'b0, 1'b0, 4'd8, 4'h8, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'h4, 4'h0, 1'b1);
            check_all($sformatf("ack_held%0d", i), 4'h0, 1'b0, 1'b0, 4'd8, 4'h8, 1'b1);
        end
        step(1'b0, 4'h4, 4'h0, 1'b0);

        drain_codes = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF, 4'h4};
        for (int i = 0; i < 8; i++) begin
            check_all($sformatf("drain_head%0d", i), 4'h0, 1'b0, 1'b0, 4'(8 - i), drain_codes[i], 1'b1);
            step(1'b0, 4'hE, 4'h0, 1'b1);
            step(1'b0, 4'hE, 4'h0, 1'b0);
        end
        check_all("drained", 4'h0, 1'b0, 1'b0, 4'd0, 4'hE, 1'b1);
        step(1'b0, 4'hE, 4'h0, 1'b1);
        check_all("pop_empty", 4'h0, 1'b0, 1'b0, 4'd0, 4'hE, 1'b1);
        step(1'b1, 4'hE, 4'h0, 1'b0);
        check_all("ovf_cleared", 4'h0, 1'b0, 1'b1, 4'd0, 4'hE, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
